// File: rtl/logic_station.sv
// logic_station: DEPTH-entry lane-wise AND/OR/XOR station; issue->DONE in 1 cycle, commit held until iCommitGranted.
// Define LOGIC_STATION_ANDN_EN to make op 11 compute A & ~B (otherwise op 11 is AND); issue stalls via oIssueReady.
module logic_station #(
  parameter int               WIDTH   = 32,
  parameter int               LANES   = 3,
  parameter int               DEPTH   = 4,
  parameter int               TAG_W   = 4,
  parameter int               DST_W   = 8,
  parameter logic [TAG_W-1:0] BASE_ID = TAG_W'(2)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iIssueValid,
  input  logic [1:0]             iIssueOp,
  input  logic [DST_W-1:0]       iIssueDst,
  input  logic [LANES-1:0]       iIssueWE,
  input  logic [LANES*WIDTH-1:0] iIssueA,
  input  logic [TAG_W-1:0]       iIssueATag,
  input  logic [LANES*WIDTH-1:0] iIssueB,
  input  logic [TAG_W-1:0]       iIssueBTag,
  output logic                   oIssueReady,
  input  logic                   iCommitValid,
  input  logic [TAG_W-1:0]       iCommitTag,
  input  logic [LANES*WIDTH-1:0] iCommitData,
  output logic                   oCommitRequest,
  input  logic                   iCommitGranted,
  output logic [TAG_W-1:0]       oCommitId,
  output logic [LANES-1:0]       oCommitWE,
  output logic [DST_W-1:0]       oCommitDst,
  output logic [LANES*WIDTH-1:0] oCommitData,
  output logic                   oBusy
);
  localparam int DW = LANES * WIDTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [DST_W-1:0] dst;
    logic [LANES-1:0] we;
    logic [TAG_W-1:0] atag;
    logic [TAG_W-1:0] btag;
    logic [DW-1:0]    a;
    logic [DW-1:0]    b;
  } entry_t;

  state_t           st_q  [DEPTH];
  state_t           st_d  [DEPTH];
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic             ptr_vld_q, ptr_vld_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TAG_W-1:0] cid_q, cid_d;
  logic [LANES-1:0] cwe_q, cwe_d;
  logic [DST_W-1:0] cdst_q, cdst_d;
  logic [DW-1:0]    cdata_q, cdata_d;
  logic             issue_hit, exec_hit;
  logic [IW-1:0]    issue_idx, exec_idx;
  logic [DW-1:0]    exec_res;

  // Operands are plain bit vectors, so a full-width bitwise op is lane-wise by construction.
  function automatic logic [DW-1:0] logic_op(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      2'b01:   return a | b;
      2'b10:   return a ^ b;
`ifdef LOGIC_STATION_ANDN_EN
      2'b11:   return a & ~b;
`endif
      default: return a & b;
    endcase
  endfunction

  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    exec_hit  = 1'b0;
    exec_idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (st_q[k] == S_FREE)  begin issue_hit = 1'b1; issue_idx = IW'(k); end
      if (st_q[k] == S_READY) begin exec_hit  = 1'b1; exec_idx  = IW'(k); end
    end
  end

  assign exec_res = logic_op(ent_q[exec_idx].op, ent_q[exec_idx].a, ent_q[exec_idx].b);

  always_comb begin
    logic [TAG_W-1:0] id;
    entry_t           e;
    logic             load;
    logic             live;
    ptr_vld_d = ptr_vld_q;
    ptr_d     = ptr_q;
    cid_d     = cid_q;
    cwe_d     = cwe_q;
    cdst_d    = cdst_q;
    cdata_d   = cdata_q;
    for (int k = 0; k < DEPTH; k++) begin
      id       = BASE_ID + TAG_W'(k);
      e        = ent_q[k];
      st_d[k]  = st_q[k];
      load     = (st_q[k] == S_FREE) && iIssueValid && issue_hit && (issue_idx == IW'(k));
      live     = load || (st_q[k] == S_WAIT);
      if (load) begin
        e.op   = iIssueOp;
        e.dst  = iIssueDst;
        e.we   = iIssueWE;
        e.a    = iIssueA;
        e.b    = iIssueB;
        e.atag = iIssueATag;
        e.btag = iIssueBTag;
      end
      // Snooping also applies to the packet being issued, so a same-edge producer is not missed.
      if (live && iCommitValid && (iCommitTag != id)) begin
        if ((e.atag != '0) && (e.atag == iCommitTag)) begin e.a = iCommitData; e.atag = '0; end
        if ((e.btag != '0) && (e.btag == iCommitTag)) begin e.b = iCommitData; e.btag = '0; end
      end
      if (live) st_d[k] = ((e.atag == '0) && (e.btag == '0)) ? S_READY : S_WAIT;
      if ((st_q[k] == S_READY) && exec_hit && (exec_idx == IW'(k))) begin
        e.a     = exec_res;
        st_d[k] = S_DONE;
      end
      if ((st_q[k] == S_DONE) && ptr_vld_q && iCommitGranted && (ptr_q == IW'(k)))
        st_d[k] = S_FREE;
      ent_d[k] = e;
    end
    // Selecting from next state lets a result request on the same edge it completes.
    if (!ptr_vld_q) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (st_d[k] == S_DONE) begin
          ptr_vld_d = 1'b1;
          ptr_d     = IW'(k);
          cid_d     = BASE_ID + TAG_W'(k);
          cwe_d     = ent_d[k].we;
          cdst_d    = ent_d[k].dst;
          cdata_d   = ent_d[k].a;
        end
      end
    end else if (iCommitGranted) begin
      ptr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        st_q[k]  <= S_FREE;
        ent_q[k] <= '0;
      end
      ptr_vld_q <= 1'b0;
      ptr_q     <= '0;
      cid_q     <= '0;
      cwe_q     <= '0;
      cdst_q    <= '0;
      cdata_q   <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        st_q[k]  <= st_d[k];
        ent_q[k] <= ent_d[k];
      end
      ptr_vld_q <= ptr_vld_d;
      ptr_q     <= ptr_d;
      cid_q     <= cid_d;
      cwe_q     <= cwe_d;
      cdst_q    <= cdst_d;
      cdata_q   <= cdata_d;
    end
  end

  always_comb begin
    oBusy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (st_q[k] != S_FREE) oBusy = 1'b1;
    end
  end

  assign oIssueReady    = issue_hit;
  assign oCommitRequest = ptr_vld_q;
  assign oCommitId      = cid_q;
  assign oCommitWE      = cwe_q;
  assign oCommitDst     = cdst_q;
  assign oCommitData    = cdata_q;
endmodule

// File: tb/tb_logic_station.sv
// Directed and randomized bench for logic_station; expected results come from a per-ID operand/occupancy model.
// Honours LOGIC_STATION_ANDN_EN when choosing the op 11 expectation.
module tb_logic_station;
  localparam int DW = 96;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iIssueValid;
  logic [1:0]    iIssueOp;
  logic [7:0]    iIssueDst;
  logic [2:0]    iIssueWE;
  logic [DW-1:0] iIssueA, iIssueB;
  logic [3:0]    iIssueATag, iIssueBTag;
  logic          oIssueReady;
  logic          iCommitValid;
  logic [3:0]    iCommitTag;
  logic [DW-1:0] iCommitData;
  logic          oCommitRequest;
  logic          iCommitGranted;
  logic [3:0]    oCommitId;
  logic [2:0]    oCommitWE;
  logic [7:0]    oCommitDst;
  logic [DW-1:0] oCommitData;
  logic          oBusy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]    m_occ;
  logic [1:0]    m_op  [4];
  logic [DW-1:0] m_a   [4];
  logic [DW-1:0] m_b   [4];
  logic [3:0]    m_at  [4];
  logic [3:0]    m_bt  [4];
  logic [7:0]    m_dst [4];
  logic [2:0]    m_we  [4];

  logic_station dut (
    .Clock(Clock), .Reset(Reset),
    .iIssueValid(iIssueValid), .iIssueOp(iIssueOp), .iIssueDst(iIssueDst), .iIssueWE(iIssueWE),
    .iIssueA(iIssueA), .iIssueATag(iIssueATag), .iIssueB(iIssueB), .iIssueBTag(iIssueBTag),
    .oIssueReady(oIssueReady),
    .iCommitValid(iCommitValid), .iCommitTag(iCommitTag), .iCommitData(iCommitData),
    .oCommitRequest(oCommitRequest), .iCommitGranted(iCommitGranted),
    .oCommitId(oCommitId), .oCommitWE(oCommitWE), .oCommitDst(oCommitDst),
    .oCommitData(oCommitData), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    if (op == 2'd1) return a | b;
    if (op == 2'd2) return a ^ b;
`ifdef LOGIC_STATION_ANDN_EN
    if (op == 2'd3) return a & ~b;
`endif
    return a & b;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    iIssueValid = 1'b0; iIssueOp = '0; iIssueDst = '0; iIssueWE = '0;
    iIssueA = '0; iIssueB = '0; iIssueATag = '0; iIssueBTag = '0;
    iCommitValid = 1'b0; iCommitTag = '0; iCommitData = '0; iCommitGranted = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [3:0] at,
                       input logic [DW-1:0] b, input logic [3:0] bt, input logic [7:0] dst);
    iIssueValid = 1'b1; iIssueOp = op; iIssueDst = dst; iIssueWE = 3'b111;
    iIssueA = a; iIssueATag = at; iIssueB = b; iIssueBTag = bt;
  endtask

  task automatic grant();
    iCommitGranted = 1'b1;
    tick();
    iCommitGranted = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!oCommitRequest && n < 50) begin tick(); n++; end
    check(tag, DW'(oCommitRequest), DW'(1));
  endtask

  // One random cycle: check status against the model, drive inputs, then advance the model to the coming edge.
  task automatic rstep(input bit allow_issue);
    int free_idx;
    int g;
    free_idx = -1;
    for (int i = 3; i >= 0; i--) if (!m_occ[i]) free_idx = i;
    check("rnd_ready", DW'(oIssueReady), DW'(free_idx >= 0));
    check("rnd_busy", DW'(oBusy), DW'(m_occ != 4'b0));
    iIssueValid    = allow_issue && ($urandom_range(0, 9) < 6);
    iIssueOp       = 2'($urandom_range(0, 3));
    iIssueDst      = 8'($urandom);
    iIssueWE       = 3'($urandom);
    iIssueA        = {$urandom, $urandom, $urandom};
    iIssueB        = {$urandom, $urandom, $urandom};
    iIssueATag     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(12, 15)) : 4'h0;
    iIssueBTag     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(12, 15)) : 4'h0;
    iCommitValid   = allow_issue ? ($urandom_range(0, 3) == 0) : 1'b1;
    iCommitTag     = 4'($urandom_range(12, 15));
    iCommitData    = {$urandom, $urandom, $urandom};
    iCommitGranted = 1'($urandom_range(0, 1));
    if (oCommitRequest && iCommitGranted) begin
      g = int'(oCommitId) - 2;
      check("rnd_gnt_id", DW'((g >= 0) && (g <= 3) && m_occ[g[1:0]]), DW'(1));
      if (g >= 0 && g <= 3) begin
        check("rnd_data", oCommitData, ref_op(m_op[g], m_a[g], m_b[g]));
        check("rnd_dst", DW'(oCommitDst), DW'(m_dst[g]));
        check("rnd_we", DW'(oCommitWE), DW'(m_we[g]));
        m_occ[g] = 1'b0;
      end
    end
    if (iCommitValid) begin
      for (int i = 0; i < 4; i++) begin
        if (m_occ[i] && m_at[i] != 4'h0 && m_at[i] == iCommitTag) begin m_a[i] = iCommitData; m_at[i] = 4'h0; end
        if (m_occ[i] && m_bt[i] != 4'h0 && m_bt[i] == iCommitTag) begin m_b[i] = iCommitData; m_bt[i] = 4'h0; end
      end
    end
    if (iIssueValid && free_idx >= 0) begin
      m_occ[free_idx] = 1'b1;
      m_op[free_idx]  = iIssueOp;
      m_dst[free_idx] = iIssueDst;
      m_we[free_idx]  = iIssueWE;
      m_a[free_idx]   = iIssueA;
      m_b[free_idx]   = iIssueB;
      m_at[free_idx]  = iIssueATag;
      m_bt[free_idx]  = iIssueBTag;
      if (iCommitValid && iIssueATag != 4'h0 && iIssueATag == iCommitTag) begin m_a[free_idx] = iCommitData; m_at[free_idx] = 4'h0; end
      if (iCommitValid && iIssueBTag != 4'h0 && iIssueBTag == iCommitTag) begin m_b[free_idx] = iCommitData; m_bt[free_idx] = 4'h0; end
    end
    tick();
  endtask

  initial begin
    logic [31:0] v;
    logic        seen;
    int          n;
    idle();
    Reset = 1'b1;
    tick();
    tick();
    check("rst_req", DW'(oCommitRequest), DW'(0));
    check("rst_busy", DW'(oBusy), DW'(0));
    check("rst_ready", DW'(oIssueReady), DW'(1));
    check("rst_data", oCommitData, '0);
    Reset = 1'b0;
    tick();

    // AND with both operands valid
    issue(2'd0, rep(32'hFF00FF00), 4'h0, rep(32'h0F0F0F0F), 4'h0, 8'h11);
    tick();
    idle();
    check("and_lat_early", DW'(oCommitRequest), DW'(0));
    check("and_busy", DW'(oBusy), DW'(1));
    tick();
    check("and_req", DW'(oCommitRequest), DW'(1));
    check("and_data", oCommitData, rep(32'h0F000F00));
    check("and_id", DW'(oCommitId), DW'(4'h2));
    check("and_dst", DW'(oCommitDst), DW'(8'h11));
    check("and_we", DW'(oCommitWE), DW'(3'b111));
    grant();
    check("and_req_off", DW'(oCommitRequest), DW'(0));
    check("and_busy_off", DW'(oBusy), DW'(0));
    check("and_data_hold", oCommitData, rep(32'h0F000F00));

    // XOR waiting on tag 7
    issue(2'd2, rep(32'h0), 4'h7, rep(32'hFFFFFFFF), 4'h0, 8'h22);
    tick();
    idle();
    tick();
    check("xor_wait", DW'(oCommitRequest), DW'(0));
    iCommitValid = 1'b1; iCommitTag = 4'h7; iCommitData = rep(32'hAAAAAAAA);
    tick();
    idle();
    check("xor_ready_noreq", DW'(oCommitRequest), DW'(0));
    tick();
    check("xor_req", DW'(oCommitRequest), DW'(1));
    check("xor_data", oCommitData, rep(32'h55555555));
    grant();

    // OR with same-edge bypass on B
    issue(2'd1, rep(32'h0F000000), 4'h0, rep(32'hDEADBEEF), 4'h5, 8'h33);
    iCommitValid = 1'b1; iCommitTag = 4'h5; iCommitData = rep(32'h12345678);
    tick();
    idle();
    tick();
    check("byp_req", DW'(oCommitRequest), DW'(1));
    check("byp_data", oCommitData, rep(32'h1F345678));
    grant();

    // Fill all entries with grant held low
    for (int i = 0; i < 4; i++) begin
      v = 32'h11111111 * 32'(i + 1);
      issue(2'd0, rep(v), 4'h0, rep(32'hFFFFFFFF), 4'h0, 8'h40 + 8'(i));
      tick();
    end
    check("full_ready", DW'(oIssueReady), DW'(0));
    issue(2'd0, rep(32'hDEAD0000), 4'h0, rep(32'hFFFFFFFF), 4'h0, 8'h99);
    tick();
    idle();
    check("full_ready2", DW'(oIssueReady), DW'(0));
    check("full_id0", DW'(oCommitId), DW'(4'h2));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_req", DW'(oCommitRequest), DW'(1));
      check("hold_data", oCommitData, rep(32'h11111111));
      check("hold_id", DW'(oCommitId), DW'(4'h2));
    end
    grant();
    check("free_ready", DW'(oIssueReady), DW'(1));
    check("gap_req", DW'(oCommitRequest), DW'(0));
    for (int j = 1; j < 4; j++) begin
      wait_req("order_req");
      v = 32'h11111111 * 32'(j + 1);
      check("order_id", DW'(oCommitId), DW'(4'h2 + 4'(j)));
      check("order_data", oCommitData, rep(v));
      check("order_dst", DW'(oCommitDst), DW'(8'h40 + 8'(j)));
      grant();
    end
    tick();
    check("drain_busy", DW'(oBusy), DW'(0));
    check("drain_req", DW'(oCommitRequest), DW'(0));

    // Reset while an entry waits
    issue(2'd0, rep(32'h1), 4'h9, rep(32'h1), 4'h0, 8'h55);
    tick();
    idle();
    tick();
    check("rw_wait", DW'(oCommitRequest), DW'(0));
    Reset = 1'b1;
    #1;
    check("rw_req", DW'(oCommitRequest), DW'(0));
    check("rw_busy", DW'(oBusy), DW'(0));
    check("rw_ready", DW'(oIssueReady), DW'(1));
    check("rw_id", DW'(oCommitId), DW'(0));
    check("rw_data", oCommitData, '0);
    tick();
    Reset = 1'b0;
    iCommitValid = 1'b1; iCommitTag = 4'h9; iCommitData = rep(32'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle();
      seen = seen | oCommitRequest | oBusy;
    end
    check("rw_nocommit", DW'(seen), DW'(0));

    // op 11
    issue(2'd3, rep(32'hF0F0F0F0), 4'h0, rep(32'hFF000000), 4'h0, 8'h66);
    tick();
    idle();
    tick();
    check("op3_req", DW'(oCommitRequest), DW'(1));
`ifdef LOGIC_STATION_ANDN_EN
    check("op3_data", oCommitData, rep(32'h00F0F0F0));
`else
    check("op3_data", oCommitData, rep(32'hF0000000));
`endif
    grant();
    tick();

    // Randomized traffic against the model, then drain
    m_occ = 4'b0;
    for (int i = 0; i < 400; i++) rstep(1'b1);
    n = 0;
    while ((m_occ != 4'b0 || oBusy) && n < 400) begin rstep(1'b0); n++; end
    idle();
    tick();
    check("rnd_drained_model", DW'(m_occ), DW'(0));
    check("rnd_drained_busy", DW'(oBusy), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
